pipeline_hazard_controller: RTL

Central stall/flush sequencer for the five-stage pipeline. Watches ID-stage source registers, the ID/EX load destination, the EX/MEM branch outcome and the data-memory handshake. Drives write-enables and flushes for the PC and every pipeline register. Also sequences post-reset pipeline clearing, because the stage registers themselves carry no reset.

---
 rtl/pipeline_hazard_controller_pkg.sv | 63 ++++++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings and output bundles for the pipeline hazard controller.
// Pulled into the top and the hazard_detect comparator with a package import.
package pipeline_hazard_controller_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] CTRL_INIT     = 2'd0;
   localparam logic [1:0] CTRL_RUN      = 2'd1;
   localparam logic [1:0] CTRL_MEM_WAIT = 2'd2;

   typedef struct packed {
      logic pc_write;
      logic pc_src;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic back_write;
   } ctrl_out_t;

   // Back stages keep clocking during INIT so the flushed zeros propagate to the end.
   function automatic ctrl_out_t init_outputs();
      ctrl_out_t o;
      o.pc_write     = 1'b0;
      o.pc_src       = 1'b0;
      o.if_id_write  = 1'b0;
      o.if_id_flush  = 1'b1;
      o.id_ex_flush  = 1'b1;
      o.ex_mem_flush = 1'b1;
      o.back_write   = 1'b1;
      return o;
   endfunction

   function automatic ctrl_out_t freeze_outputs();
      ctrl_out_t o;
      o = '0;
      return o;
   endfunction

   // Branch outranks load-use: the stalled instruction is squashed anyway.
   function automatic ctrl_out_t decode_run(input logic branch_taken, input logic load_use);
      ctrl_out_t o;
      o.pc_write     = 1'b1;
      o.pc_src       = 1'b0;
      o.if_id_write  = 1'b1;
      o.if_id_flush  = 1'b0;
      o.id_ex_flush  = 1'b0;
      o.ex_mem_flush = 1'b0;
      o.back_write   = 1'b1;
      if (branch_taken) begin
         o.pc_src       = 1'b1;
         o.if_id_flush  = 1'b1;
         o.id_ex_flush  = 1'b1;
         o.ex_mem_flush = 1'b1;
      end else if (load_use) begin
         o.pc_write    = 1'b0;
         o.if_id_write = 1'b0;
         o.id_ex_flush = 1'b1;
      end
      return o;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
// Register 0 is hard-wired, so a load targeting it never creates a dependency.
module hazard_detect
   import pipeline_hazard_controller_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
   output logic                  load_use
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_write_reg_addr == id_rs_addr);
      rt_match = id_uses_rt && (ex_write_reg_addr == id_rt_addr);
      load_use = ex_mem_read && (ex_write_reg_addr != '0) && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline, including post-reset pipeline clearing.
// Define PIPE_PERF_COUNTERS_EN to add the saturating stall_count/flush_count ports.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
   input  logic                  mem_branch,
   input  logic                  mem_alu_zero,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  back_write,
   output logic [1:0]            ctrl_state,
   output logic                  mem_timeout
`ifdef PIPE_PERF_COUNTERS_EN
   ,
   output logic [31:0]           stall_count,
   output logic [31:0]           flush_count
`endif
);

   localparam int              INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [7:0]      TIMEOUT_LIM = 8'(MEM_TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic              load_use;
   logic              branch_taken;
   logic              mem_hold;
   logic              active;
   ctrl_out_t         outs;

   hazard_detect u_hazard_detect (
      .id_rs_addr        (id_rs_addr),
      .id_rt_addr        (id_rt_addr),
      .id_uses_rt        (id_uses_rt),
      .ex_mem_read       (ex_mem_read),
      .ex_write_reg_addr (ex_write_reg_addr),
      .load_use          (load_use)
   );

   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_hold      = 1'b0;
      branch_taken  = mem_branch && mem_alu_zero;
      outs          = decode_run(branch_taken, load_use);
      active        = (state_q == CTRL_RUN) || (state_q == CTRL_MEM_WAIT);

      case (state_q)
         CTRL_INIT: begin
            outs = init_outputs();
            if (init_cnt_q == INIT_LAST) begin
               state_d = CTRL_RUN;
            end else begin
               init_cnt_d = init_cnt_q + INIT_W'(1);
            end
         end
         CTRL_RUN: begin
            if (mem_req && !mem_ready) begin
               outs       = freeze_outputs();
               mem_hold   = 1'b1;
               state_d    = CTRL_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         CTRL_MEM_WAIT: begin
            // Hazards seen while waiting are only acted on in the ready cycle.
            if (!mem_ready) begin
               outs     = freeze_outputs();
               mem_hold = 1'b1;
               if (wait_cnt_q != 8'hFF) begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               state_d = CTRL_RUN;
            end
         end
         default: begin
            outs       = init_outputs();
            state_d    = CTRL_INIT;
            init_cnt_d = '0;
         end
      endcase

      mem_timeout_d = mem_timeout_q || (mem_hold && (wait_cnt_d >= TIMEOUT_LIM));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= CTRL_INIT;
         init_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

`ifdef PIPE_PERF_COUNTERS_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (active && !outs.pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      if (active && outs.pc_src && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`else
   logic unused_active;
   assign unused_active = active;
`endif

   assign pc_write     = outs.pc_write;
   assign pc_src       = outs.pc_src;
   assign if_id_write  = outs.if_id_write;
   assign if_id_flush  = outs.if_id_flush;
   assign id_ex_flush  = outs.id_ex_flush;
   assign ex_mem_flush = outs.ex_mem_flush;
   assign back_write   = outs.back_write;
   assign ctrl_state   = state_q;
   assign mem_timeout  = mem_timeout_q;

endmodule
